riscv_ex_stage: RTL and testbench

- RV32I execute stage, located between the ID stage and the MEM stage.
- Accepts one decoded instruction per cycle over a valid/ready handshake and selects the operands, applying forwarding.
- Derives the 4-bit ALU op, instantiates riscv_alu, and registers the result into a single EX/MEM output register.
- Latency: 1 cycle.

---
 rtl/riscv_ex_stage.sv | 216 +++++++++++++++++++++
 tb/tb_riscv_ex_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ex_stage.sv
// RV32I execute stage: operand select with forwarding, ALU-op decode and a
// single EX/MEM output register behind a valid/ready handshake.

module riscv_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  logic [4:0] w_shamt;
  assign w_shamt = i_b[4:0];

  // Combinational ALU; codes 10..15 are never generated and yield 0.
  always_comb begin
    o_result = '0;
    case (i_op)
      AluAdd:  o_result = i_a + i_b;
      AluSub:  o_result = i_a - i_b;
      AluSll:  o_result = i_a << w_shamt;
      AluSlt:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      AluSltu: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      AluXor:  o_result = i_a ^ i_b;
      AluSrl:  o_result = i_a >> w_shamt;
      AluSra:  o_result = XLEN'($signed(i_a) >>> w_shamt);
      AluOr:   o_result = i_a | i_b;
      AluAnd:  o_result = i_a & i_b;
      default: o_result = '0;
    endcase
  end
endmodule

module riscv_ex_stage #(
  parameter int unsigned XLEN       = 32,
  parameter bit          ENABLE_FWD = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [6:0]      i_id_opcode,
  input  logic [2:0]      i_id_funct3,
  input  logic            i_id_funct7_5,
  input  logic [4:0]      i_id_rs1_addr,
  input  logic [4:0]      i_id_rs2_addr,
  input  logic [4:0]      i_id_rd_addr,
  input  logic [XLEN-1:0] i_id_rs1_val,
  input  logic [XLEN-1:0] i_id_rs2_val,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_ex_valid,
  input  logic            i_ex_ready,
  output logic [XLEN-1:0] o_ex_result,
  output logic [XLEN-1:0] o_ex_rs2_val,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [4:0]      o_ex_rd,
  output logic            o_ex_rd_we,
  output logic            o_ex_illegal
);
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rd;
  logic            r_rd_we;
  logic            r_illegal;

  logic            w_transfer;
  logic [XLEN-1:0] w_rs1;
  logic [XLEN-1:0] w_rs2;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [3:0]      w_op;
  logic [3:0]      w_f3_op;
  logic            w_rd_we;
  logic            w_illegal;
  logic [XLEN-1:0] w_alu_result;

  assign o_id_ready = !r_valid || i_ex_ready;
  assign w_transfer = i_id_valid && o_id_ready;

  // Operand forwarding: own output register beats WB; x0 always reads zero.
  always_comb begin
    w_rs1 = i_id_rs1_val;
    w_rs2 = i_id_rs2_val;
    if (ENABLE_FWD) begin
      if (r_valid && r_rd_we && (r_rd == i_id_rs1_addr)) begin
        w_rs1 = r_result;
      end else if (i_wb_we && (i_wb_rd == i_id_rs1_addr)) begin
        w_rs1 = i_wb_data;
      end
      if (r_valid && r_rd_we && (r_rd == i_id_rs2_addr)) begin
        w_rs2 = r_result;
      end else if (i_wb_we && (i_wb_rd == i_id_rs2_addr)) begin
        w_rs2 = i_wb_data;
      end
    end
    if (i_id_rs1_addr == 5'd0) w_rs1 = '0;
    if (i_id_rs2_addr == 5'd0) w_rs2 = '0;
  end

  // funct3 -> ALU op for OP / OP-IMM; funct7_5 selects SUB only for register OP.
  always_comb begin
    w_f3_op = AluAdd;
    case (i_id_funct3)
      3'b000:  w_f3_op = (i_id_opcode == OpcOp && i_id_funct7_5) ? AluSub : AluAdd;
      3'b001:  w_f3_op = AluSll;
      3'b010:  w_f3_op = AluSlt;
      3'b011:  w_f3_op = AluSltu;
      3'b100:  w_f3_op = AluXor;
      3'b101:  w_f3_op = i_id_funct7_5 ? AluSra : AluSrl;
      3'b110:  w_f3_op = AluOr;
      default: w_f3_op = AluAnd;
    endcase
  end

  // Opcode decode; an illegal opcode feeds 0 + 0 so the result is zero.
  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_op      = AluAdd;
    w_rd_we   = 1'b0;
    w_illegal = 1'b0;
    case (i_id_opcode)
      OpcOp:     begin w_a = w_rs1;   w_b = w_rs2;    w_op = w_f3_op; w_rd_we = 1'b1; end
      OpcOpImm:  begin w_a = w_rs1;   w_b = i_id_imm; w_op = w_f3_op; w_rd_we = 1'b1; end
      OpcLui:    begin                w_b = i_id_imm;                 w_rd_we = 1'b1; end
      OpcAuipc:  begin w_a = i_id_pc; w_b = i_id_imm;                 w_rd_we = 1'b1; end
      OpcJal,
      OpcJalr:   begin w_a = i_id_pc; w_b = XLEN'(4);                 w_rd_we = 1'b1; end
      OpcLoad:   begin w_a = w_rs1;   w_b = i_id_imm;                 w_rd_we = 1'b1; end
      OpcStore:  begin w_a = w_rs1;   w_b = i_id_imm;                                 end
      OpcBranch: begin w_a = w_rs1;   w_b = w_rs2;    w_op = AluSub;                  end
      default:   w_illegal = 1'b1;
    endcase
  end

  riscv_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .i_op     (w_op),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_alu_result)
  );

  // EX/MEM register: flush wins, then transfer, then drain on ex_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_rs2_val <= '0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_transfer) begin
      r_valid   <= 1'b1;
      r_result  <= w_alu_result;
      r_rs2_val <= w_rs2;
      r_pc      <= i_id_pc;
      r_rd      <= i_id_rd_addr;
      r_rd_we   <= w_rd_we && (i_id_rd_addr != 5'd0);
      r_illegal <= w_illegal;
    end else if (i_ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ex_valid   = r_valid;
  assign o_ex_result  = r_result;
  assign o_ex_rs2_val = r_rs2_val;
  assign o_ex_pc      = r_pc;
  assign o_ex_rd      = r_rd;
  assign o_ex_rd_we   = r_rd_we;
  assign o_ex_illegal = r_illegal;
endmodule

// File: tb/tb_riscv_ex_stage.sv
// Self-checking bench for riscv_ex_stage: directed scenarios plus a randomized
// stream checked against a cycle-level behavioural model.

module tb_riscv_ex_stage;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_f75;
  logic [4:0]  rs1a, rs2a, rda;
  logic [31:0] rs1v, rs2v, imm;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result, ex_rs2_val, ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_rd_we, ex_illegal;

  int n_total = 0;
  int n_bad   = 0;

  // Model of the output register contents.
  logic        m_valid;
  logic [31:0] m_result, m_rs2, m_pc;
  logic [4:0]  m_rd;
  logic        m_rd_we, m_ill;

  riscv_ex_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (flush),
    .i_id_valid    (id_valid),
    .o_id_ready    (id_ready),
    .i_id_pc       (id_pc),
    .i_id_opcode   (id_opcode),
    .i_id_funct3   (id_funct3),
    .i_id_funct7_5 (id_f75),
    .i_id_rs1_addr (rs1a),
    .i_id_rs2_addr (rs2a),
    .i_id_rd_addr  (rda),
    .i_id_rs1_val  (rs1v),
    .i_id_rs2_val  (rs2v),
    .i_id_imm      (imm),
    .i_wb_we       (wb_we),
    .i_wb_rd       (wb_rd),
    .i_wb_data     (wb_data),
    .o_ex_valid    (ex_valid),
    .i_ex_ready    (ex_ready),
    .o_ex_result   (ex_result),
    .o_ex_rs2_val  (ex_rs2_val),
    .o_ex_pc       (ex_pc),
    .o_ex_rd       (ex_rd),
    .o_ex_rd_we    (ex_rd_we),
    .o_ex_illegal  (ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                           input logic [31:0] v1, input logic [31:0] v2,
                           input logic [31:0] im, input logic [31:0] pc);
    id_opcode = op; id_funct3 = f3; id_f75 = f75;
    rs1a = a1; rs2a = a2; rda = rd;
    rs1v = v1; rs2v = v2; imm = im; id_pc = pc;
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (f3)
      3'd0: r = alt ? x - y : x + y;
      3'd1: r = x << y[4:0];
      3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: r = (x < y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: if (alt) r = $signed(x) >>> y[4:0]; else r = x >> y[4:0];
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (m_valid && m_rd_we && m_rd == a) return m_result;
    if (wb_we && wb_rd == a) return wb_data;
    return rf;
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    logic xfer, we, ill;
    logic [31:0] a, b, res;
    xfer = id_valid && (!m_valid || ex_ready);
    a = fwd(rs1a, rs1v);
    b = fwd(rs2a, rs2v);
    we = 1'b1; ill = 1'b0; res = 32'd0;
    case (id_opcode)
      7'b0110011: res = ref_alu(id_funct3, id_f75, a, b);
      7'b0010011: res = ref_alu(id_funct3, (id_funct3 == 3'd5) && id_f75, a, imm);
      7'b0110111: res = imm;
      7'b0010111: res = id_pc + imm;
      7'b1101111, 7'b1100111: res = id_pc + 32'd4;
      7'b0000011: res = a + imm;
      7'b0100011: begin res = a + imm; we = 1'b0; end
      7'b1100011: begin res = a - b; we = 1'b0; end
      default: begin we = 1'b0; ill = 1'b1; end
    endcase
    if (flush) m_valid = 1'b0;
    else if (xfer) begin
      m_valid = 1'b1; m_result = res; m_rs2 = b; m_pc = id_pc; m_rd = rda;
      m_rd_we = we && (rda != 5'd0); m_ill = ill;
    end else if (ex_ready) m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    set_instr(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #2;
    n_total++;
    if ({ex_valid, ex_result, ex_rs2_val, ex_pc, ex_rd, ex_rd_we, ex_illegal} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b res=%h rs2=%h pc=%h rd=%0d we=%0b ill=%0b want all 0",
               ex_valid, ex_result, ex_rs2_val, ex_pc, ex_rd, ex_rd_we, ex_illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (id_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_id_ready: got %b want 1", id_ready);
    end
  endtask

  task automatic test_addi();
    tick();
    set_instr(7'b0010011, 3'd0, 1'b1, 5'd0, 5'd0, 5'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'h10);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    n_total++;
    if (ex_valid !== 1'b1 || ex_result !== 32'hFFFF_FFFF || ex_rd !== 5'd5 ||
        ex_rd_we !== 1'b1 || ex_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL addi: got v=%b res=%h rd=%0d we=%b ill=%b want v=1 res=ffffffff rd=5 we=1 ill=0",
               ex_valid, ex_result, ex_rd, ex_rd_we, ex_illegal);
    end
    tick();
    n_total++;
    if (ex_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_drain: got ex_valid=%b want 0", ex_valid);
    end
  endtask

  task automatic test_fwd_own();
    set_instr(7'b0110011, 3'd0, 1'b0, 5'd2, 5'd3, 5'd1, 32'd3, 32'd4, 32'd0, 32'h20);
    id_valid = 1'b1;
    tick();
    n_total++;
    if (ex_result !== 32'd7) begin
      n_bad++;
      $display("FAIL add_3_4: got %h want 00000007", ex_result);
    end
    set_instr(7'b0110011, 3'd0, 1'b1, 5'd1, 5'd4, 5'd2, 32'd0, 32'd10, 32'd0, 32'h24);
    tick();
    id_valid = 1'b0;
    n_total++;
    if (ex_result !== 32'hFFFF_FFFD || ex_rd !== 5'd2) begin
      n_bad++;
      $display("FAIL fwd_own_sub: got res=%h rd=%0d want fffffffd rd=2", ex_result, ex_rd);
    end
    tick();
  endtask

  task automatic test_fwd_wb();
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h8000_0000;
    set_instr(7'b0010011, 3'd5, 1'b1, 5'd7, 5'd0, 5'd8, 32'd0, 32'd0, 32'h0000_0404, 32'h30);
    id_valid = 1'b1;
    tick();
    n_total++;
    if (ex_result !== 32'hF800_0000 || ex_rd_we !== 1'b1) begin
      n_bad++;
      $display("FAIL fwd_wb_srai: got res=%h we=%b want f8000000 we=1", ex_result, ex_rd_we);
    end
    rda = 5'd0;
    tick();
    id_valid = 1'b0; wb_we = 1'b0;
    n_total++;
    if (ex_result !== 32'hF800_0000 || ex_rd_we !== 1'b0) begin
      n_bad++;
      $display("FAIL srai_rd0: got res=%h we=%b want f8000000 we=0", ex_result, ex_rd_we);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] imms[4];
    imms = '{32'h11, 32'h22, 32'h33, 32'h44};
    ex_ready = 1'b0;
    set_instr(7'b0010011, 3'd0, 1'b0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, imms[0], 32'h40);
    id_valid = 1'b1;
    tick();
    imm = imms[1]; id_pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (id_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_id_ready[%0d]: got %b want 0", i, id_ready);
      end
      tick();
      n_total++;
      if (ex_valid !== 1'b1 || ex_result !== imms[0] || ex_pc !== 32'h40) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got v=%b res=%h pc=%h want v=1 res=%h pc=00000040",
                 i, ex_valid, ex_result, ex_pc, imms[0]);
      end
    end
    ex_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      imm = imms[i]; id_pc = 32'h40 + 32'(4 * i);
      tick();
      n_total++;
      if (ex_valid !== 1'b1 || ex_result !== imms[i]) begin
        n_bad++;
        $display("FAIL stream[%0d]: got v=%b res=%h want v=1 res=%h", i, ex_valid, ex_result,
                 imms[i]);
      end
    end
    id_valid = 1'b0;
    tick();
    n_total++;
    if (ex_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_end: got ex_valid=%b want 0", ex_valid);
    end
  endtask

  task automatic test_jal_illegal();
    set_instr(7'b1101111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h800, 32'h100);
    id_valid = 1'b1;
    tick();
    n_total++;
    if (ex_result !== 32'h104 || ex_rd_we !== 1'b1) begin
      n_bad++;
      $display("FAIL jal_link: got res=%h we=%b want 00000104 we=1", ex_result, ex_rd_we);
    end
    set_instr(7'h7F, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd7, 32'h200);
    tick();
    id_valid = 1'b0;
    n_total++;
    if (ex_illegal !== 1'b1 || ex_rd_we !== 1'b0 || ex_result !== 32'd0) begin
      n_bad++;
      $display("FAIL illegal: got ill=%b we=%b res=%h want ill=1 we=0 res=0",
               ex_illegal, ex_rd_we, ex_result);
    end
    tick();
  endtask

  task automatic test_flush();
    set_instr(7'b0110111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'h1234_5000, 32'h300);
    id_valid = 1'b1;
    tick();
    flush = 1'b1; imm = 32'h5555_0000;
    tick();
    flush = 1'b0; id_valid = 1'b0;
    n_total++;
    if (ex_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_xfer: got ex_valid=%b want 0", ex_valid);
    end
  endtask

  task automatic test_async_reset();
    set_instr(7'b0110111, 3'd0, 1'b0, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'hABCD_E000, 32'h400);
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (ex_valid !== 1'b0 || ex_result !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b res=%h want v=0 res=0", ex_valid, ex_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops[9];
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0000011, 7'b0100011, 7'b1100011};
    m_valid = 1'b0; m_result = '0; m_rs2 = '0; m_pc = '0; m_rd = '0;
    m_rd_we = 1'b0; m_ill = 1'b0;
    for (int c = 0; c < 400; c++) begin
      id_opcode = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      id_funct3 = 3'($urandom); id_f75 = 1'($urandom);
      rs1a = 5'($urandom_range(0, 7)); rs2a = 5'($urandom_range(0, 7));
      rda = 5'($urandom_range(0, 7));
      rs1v = $urandom; rs2v = $urandom; imm = $urandom; id_pc = $urandom;
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      wb_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      n_total++;
      if (id_ready !== (!m_valid || ex_ready)) begin
        n_bad++;
        $display("FAIL rand_id_ready[%0d]: got %b want %b", c, id_ready, !m_valid || ex_ready);
      end
      model_edge();
      tick();
      n_total++;
      if (ex_valid !== m_valid || (m_valid && ({ex_result, ex_rs2_val, ex_pc, ex_rd, ex_rd_we,
          ex_illegal} !== {m_result, m_rs2, m_pc, m_rd, m_rd_we, m_ill}))) begin
        n_bad++;
        $display("FAIL rand_out[%0d]: got v=%b res=%h rs2=%h pc=%h rd=%0d we=%b ill=%b want v=%b res=%h rs2=%h pc=%h rd=%0d we=%b ill=%b",
                 c, ex_valid, ex_result, ex_rs2_val, ex_pc, ex_rd, ex_rd_we, ex_illegal,
                 m_valid, m_result, m_rs2, m_pc, m_rd, m_rd_we, m_ill);
      end
    end
    id_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; ex_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fwd_own();
    test_fwd_wb();
    test_back_to_back();
    test_jal_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
